// File: rtl/sysid_regfile_slave.sv
// System identity register file on Avalon-MM: ID, timestamp, capability word, scratch register,
// fixed-latency pipelined reads. Optional 64-bit uptime counter is enabled with SYSID_UPTIME_EN.
module sysid_regfile_slave #(
   parameter logic [31:0] SYSTEM_ID     = 32'h0000_0000,
   parameter logic [31:0] TIMESTAMP     = 32'd1457289839,
   parameter logic [15:0] VERSION       = 16'h0002,
   parameter int          READ_LATENCY  = 1,
   parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [2:0]  address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        readdatavalid
);

   generate
      if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_latency
         $error("sysid_regfile_slave: READ_LATENCY must be in 1..3");
      end
   endgenerate

   localparam logic [2:0] ADDR_ID      = 3'd0;
   localparam logic [2:0] ADDR_TS      = 3'd1;
   localparam logic [2:0] ADDR_CAP     = 3'd2;
   localparam logic [2:0] ADDR_SCRATCH = 3'd3;
   localparam logic [2:0] ADDR_UP_LO   = 3'd4;
   localparam logic [2:0] ADDR_UP_HI   = 3'd5;

`ifdef SYSID_UPTIME_EN
   localparam logic UPTIME_PRESENT = 1'b1;
`else
   localparam logic UPTIME_PRESENT = 1'b0;
`endif

   localparam logic [31:0] CAP_WORD = {VERSION, 8'(READ_LATENCY), 7'b0, UPTIME_PRESENT};

   // A read colliding with a write is dropped; the write still lands.
   logic rd_accept;
   logic wr_scratch;

   assign rd_accept  = read & ~write;
   assign wr_scratch = write && (address == ADDR_SCRATCH);

   logic [31:0] scratch;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         scratch <= SCRATCH_RESET;
      end else if (wr_scratch) begin
         scratch <= writedata;
      end
   end

   logic [31:0] uptime_lo;
   logic [31:0] uptime_hi_word;

`ifdef SYSID_UPTIME_EN
   logic [63:0] uptime;
   logic [31:0] uptime_hi_snapshot;

   // The high word is only ever returned from the snapshot taken with the low word.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         uptime             <= 64'd0;
         uptime_hi_snapshot <= 32'd0;
      end else begin
         uptime <= uptime + 64'd1;
         if (rd_accept && (address == ADDR_UP_LO)) begin
            uptime_hi_snapshot <= uptime[63:32];
         end
      end
   end

   assign uptime_lo      = uptime[31:0];
   assign uptime_hi_word = uptime_hi_snapshot;
`else
   assign uptime_lo      = 32'd0;
   assign uptime_hi_word = 32'd0;
`endif

   logic [31:0] rd_word;

   always_comb begin
      rd_word = 32'd0;
      case (address)
         ADDR_ID:      rd_word = SYSTEM_ID;
         ADDR_TS:      rd_word = TIMESTAMP;
         ADDR_CAP:     rd_word = CAP_WORD;
         ADDR_SCRATCH: rd_word = scratch;
         ADDR_UP_LO:   rd_word = uptime_lo;
         ADDR_UP_HI:   rd_word = uptime_hi_word;
         default:      rd_word = 32'd0;
      endcase
   end

   // Stage 0 captures at the accept edge; the last stage is the output register and
   // only loads on a valid response, so readdata holds between pulses.
   logic [READ_LATENCY-1:0] pipe_v;
   logic [31:0]             pipe_d [READ_LATENCY];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pipe_v <= '0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            pipe_d[i] <= 32'd0;
         end
      end else begin
         pipe_v[0] <= rd_accept;
         if (rd_accept) begin
            pipe_d[0] <= rd_word;
         end
         for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            if (pipe_v[i-1]) begin
               pipe_d[i] <= pipe_d[i-1];
            end
         end
      end
   end

   assign readdata      = pipe_d[READ_LATENCY-1];
   assign readdatavalid = pipe_v[READ_LATENCY-1];

endmodule

// File: tb/tb_sysid_regfile_slave.sv
// Randomised bench for sysid_regfile_slave against a transaction-level model of the register map.
module tb_sysid_regfile_slave;

   localparam int          RL   = 2;
   localparam logic [31:0] SID  = 32'h5A5A_1234;
   localparam logic [31:0] TS   = 32'd1457289839;
   localparam logic [15:0] VER  = 16'h0002;
   localparam logic [31:0] SRST = 32'h1234_5678;
`ifdef SYSID_UPTIME_EN
   localparam bit UP = 1'b1;
`else
   localparam bit UP = 1'b0;
`endif

   logic        clock;
   logic        reset_n;
   logic [2:0]  address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        readdatavalid;

   sysid_regfile_slave #(
      .SYSTEM_ID    (SID),
      .TIMESTAMP    (TS),
      .VERSION      (VER),
      .READ_LATENCY (RL),
      .SCRATCH_RESET(SRST)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .address      (address),
      .read         (read),
      .write        (write),
      .writedata    (writedata),
      .readdata     (readdata),
      .readdatavalid(readdatavalid)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   logic [63:0] cyc = 64'd0;
   logic [63:0] rel_cyc = 64'd0;
   always @(posedge clock) cyc <= cyc + 64'd1;

   typedef struct {
      int          due;
      logic [31:0] d;
   } resp_t;

   resp_t       q[$];
   int          ncyc = 0;
   logic [31:0] m_scratch = SRST;
   logic [31:0] m_snap = 32'd0;
   logic [31:0] last_d = 32'd0;
   bit          force_on = 1'b0;
   logic [63:0] force_val = 64'd0;
   logic        obs_v, exp_v;
   logic [31:0] obs_d, exp_d;

   function automatic logic [63:0] m_uptime();
      return force_on ? force_val : (cyc - rel_cyc);
   endfunction

   function automatic logic [31:0] m_read(input logic [2:0] a);
      logic [63:0] u;
      u = m_uptime();
      case (a)
         3'd0:    return SID;
         3'd1:    return TS;
         3'd2:    return {VER, 8'(RL), 7'b0, UP};
         3'd3:    return m_scratch;
         3'd4:    return UP ? u[31:0] : 32'd0;
         3'd5:    return UP ? m_snap : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   // Samples outputs at the falling edge, works out what the model expected there, then drives.
   task automatic tick(input bit rd, input bit wr, input logic [2:0] a, input logic [31:0] wd);
      logic [63:0] u;
      @(negedge clock);
      ncyc++;
      obs_v = readdatavalid;
      obs_d = readdata;
      if (q.size() > 0 && q[0].due == ncyc) begin
         exp_v  = 1'b1;
         exp_d  = q[0].d;
         last_d = q[0].d;
         void'(q.pop_front());
      end else begin
         exp_v = 1'b0;
         exp_d = last_d;
      end
      read      = rd;
      write     = wr;
      address   = a;
      writedata = wd;
      if (rd && wr) $display("note: protocol error, read and write asserted together at cycle %0d", ncyc);
      if (rd && !wr) begin
         q.push_back('{due: ncyc + RL, d: m_read(a)});
         if (a == 3'd4) begin
            u      = m_uptime();
            m_snap = u[63:32];
         end
      end
      if (wr && a == 3'd3) m_scratch = wd;
   endtask

   task automatic model_reset();
      q.delete();
      last_d    = 32'd0;
      m_scratch = SRST;
      m_snap    = 32'd0;
      force_on  = 1'b0;
   endtask

   task automatic test_reset();
      read = 0; write = 0; address = 0; writedata = 0;
      reset_n = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         checks++;
         if (readdatavalid !== 1'b0 || readdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: valid=%b data=%h, required valid=0 data=0", readdatavalid, readdata);
         end
      end
      reset_n = 1'b1;
      rel_cyc = cyc;
      tick(1, 0, 3'd3, 0);
      tick(1, 0, 3'd5, 0);
      for (int i = 0; i < RL + 2; i++) begin
         tick(0, 0, 0, 0);
         checks++;
         if (obs_v !== exp_v || obs_d !== exp_d) begin
            errors++;
            $display("FAIL reset_readback: valid=%b data=%h, required valid=%b data=%h", obs_v, obs_d, exp_v, exp_d);
         end
      end
   endtask

   task automatic test_idmap();
      for (int i = 0; i < 3 + RL + 2; i++) begin
         if (i < 3) tick(1, 0, 3'(i), 0);
         else       tick(0, 0, 0, 0);
         checks++;
         if (obs_v !== exp_v || obs_d !== exp_d) begin
            errors++;
            $display("FAIL idmap c%0d: valid=%b data=%h, required valid=%b data=%h", i, obs_v, obs_d, exp_v, exp_d);
         end
      end
      checks++;
      if (m_read(3'd2) !== {16'h0002, 8'(RL), 7'b0, UP} || last_d !== m_read(3'd2)) begin
         errors++;
         $display("FAIL idmap_capword: last=%h, required %h", last_d, m_read(3'd2));
      end
   endtask

   task automatic test_scratch();
      logic        rd_s[8]  = '{0, 1, 0, 1, 0, 0, 1, 0};
      logic        wr_s[8]  = '{1, 0, 1, 0, 1, 1, 0, 0};
      logic [2:0]  a_s[8]   = '{3, 3, 0, 0, 1, 5, 3, 0};
      logic [31:0] wd_s[8]  = '{32'hDEAD_BEEF, 0, 32'hFFFF_FFFF, 0, 32'h0BAD_0BAD, 32'h1111_2222, 0, 0};
      for (int i = 0; i < 8 + RL + 1; i++) begin
         if (i < 8) tick(rd_s[i], wr_s[i], a_s[i], wd_s[i]);
         else       tick(0, 0, 0, 0);
         checks++;
         if (obs_v !== exp_v || obs_d !== exp_d) begin
            errors++;
            $display("FAIL scratch c%0d: valid=%b data=%h, required valid=%b data=%h", i, obs_v, obs_d, exp_v, exp_d);
         end
      end
   endtask

   task automatic test_unmapped_collision();
      logic        rd_s[6]  = '{1, 1, 1, 0, 1, 1};
      logic        wr_s[6]  = '{0, 0, 1, 0, 0, 1};
      logic [2:0]  a_s[6]   = '{6, 7, 3, 0, 3, 0};
      logic [31:0] wd_s[6]  = '{0, 0, 32'hCAFE_F00D, 0, 0, 32'h7777_7777};
      for (int i = 0; i < 6 + RL + 2; i++) begin
         if (i < 6) tick(rd_s[i], wr_s[i], a_s[i], wd_s[i]);
         else       tick(0, 0, 0, 0);
         checks++;
         if (obs_v !== exp_v || obs_d !== exp_d) begin
            errors++;
            $display("FAIL unmapped_collision c%0d: valid=%b data=%h, required valid=%b data=%h", i, obs_v, obs_d, exp_v, exp_d);
         end
      end
   endtask

   task automatic test_back_to_back();
      bit rd, wr;
      for (int i = 0; i < 400 + RL + 2; i++) begin
         rd = ($urandom_range(0, 3) != 0);
         wr = ($urandom_range(0, 7) == 0);
         if (i < 400) tick(rd, wr, 3'($urandom_range(0, 7)), $urandom);
         else         tick(0, 0, 0, 0);
         checks++;
         if (obs_v !== exp_v || obs_d !== exp_d) begin
            errors++;
            $display("FAIL back_to_back c%0d: valid=%b data=%h, required valid=%b data=%h", i, obs_v, obs_d, exp_v, exp_d);
         end
      end
   endtask

`ifdef SYSID_UPTIME_EN
   task automatic test_uptime_coherent();
      force_on  = 1'b1;
      force_val = 64'h0000_0001_FFFF_FFFE;
      force dut.uptime = 64'h0000_0001_FFFF_FFFE;
      for (int i = 0; i < 4 + RL + 1; i++) begin
         if (i == 2) begin
            force_val = 64'h0000_0002_0000_0005;
            force dut.uptime = 64'h0000_0002_0000_0005;
         end
         if (i == 0)      tick(1, 0, 3'd4, 0);
         else if (i == 2) tick(1, 0, 3'd5, 0);
         else             tick(0, 0, 0, 0);
         checks++;
         if (obs_v !== exp_v || obs_d !== exp_d) begin
            errors++;
            $display("FAIL uptime_coherent c%0d: valid=%b data=%h, required valid=%b data=%h", i, obs_v, obs_d, exp_v, exp_d);
         end
         if (i == RL) begin
            checks++;
            if (obs_d !== 32'hFFFF_FFFE) begin
               errors++;
               $display("FAIL uptime_lo: got %h, required FFFFFFFE", obs_d);
            end
         end
         if (i == RL + 2) begin
            checks++;
            if (obs_d !== 32'h0000_0001) begin
               errors++;
               $display("FAIL uptime_hi_snapshot: got %h, required 00000001", obs_d);
            end
         end
      end
      release dut.uptime;
      force_on = 1'b0;
   endtask
`else
   task automatic test_uptime_absent();
      for (int i = 0; i < 1000; i++) begin
         tick(0, 0, 0, 0);
         if (i % 100 == 0) begin
            checks++;
            if (obs_v !== exp_v || obs_d !== exp_d) begin
               errors++;
               $display("FAIL uptime_absent_idle c%0d: valid=%b data=%h, required valid=%b data=%h", i, obs_v, obs_d, exp_v, exp_d);
            end
         end
      end
      for (int i = 0; i < 3 + RL + 1; i++) begin
         if (i < 3) tick(1, 0, 3'(i + 2), 0);
         else       tick(0, 0, 0, 0);
         checks++;
         if (obs_v !== exp_v || obs_d !== exp_d) begin
            errors++;
            $display("FAIL uptime_absent c%0d: valid=%b data=%h, required valid=%b data=%h", i, obs_v, obs_d, exp_v, exp_d);
         end
      end
   endtask
`endif

   task automatic test_reset_midop();
      tick(0, 1, 3'd3, 32'hA5A5_5A5A);
      tick(1, 0, 3'd3, 0);
      @(negedge clock);
      read = 0; write = 0;
      reset_n = 1'b0;
      model_reset();
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         checks++;
         if (readdatavalid !== 1'b0 || readdata !== 32'd0) begin
            errors++;
            $display("FAIL midop_in_reset: valid=%b data=%h, required valid=0 data=0", readdatavalid, readdata);
         end
      end
      reset_n = 1'b1;
      rel_cyc = cyc;
      for (int i = 0; i < RL + 5; i++) begin
         if (i == 3)      tick(1, 0, 3'd3, 0);
         else if (i == 4) tick(1, 0, 3'd4, 0);
         else             tick(0, 0, 0, 0);
         checks++;
         if (obs_v !== exp_v || obs_d !== exp_d) begin
            errors++;
            $display("FAIL midop_after c%0d: valid=%b data=%h, required valid=%b data=%h", i, obs_v, obs_d, exp_v, exp_d);
         end
      end
   endtask

   initial begin
      test_reset();
      test_idmap();
      test_scratch();
      test_unmapped_collision();
      test_back_to_back();
`ifdef SYSID_UPTIME_EN
      test_uptime_coherent();
`else
      test_uptime_absent();
`endif
      test_reset_midop();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
